// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, 2-bit-per-channel colour constants and the
// board cell / player encoding common with the connect-four game core.
package vga_pkg;

  localparam int H_ACTIVE   = 640;
  localparam int H_FP       = 16;
  localparam int H_SYNC     = 96;
  localparam int H_BP       = 48;
  localparam int V_ACTIVE   = 480;
  localparam int V_FP       = 10;
  localparam int V_SYNC     = 2;
  localparam int V_BP       = 33;

  localparam int BOARD_X0   = 192;
  localparam int BOARD_Y0   = 112;
  localparam int CELL_SHIFT = 5;
  localparam int FLIP_ROWS  = 1;

  // {red[1:0], green[1:0], blue[1:0]}
  typedef logic [5:0] rgb_t;

  localparam rgb_t BLACK  = 6'b00_00_00;
  localparam rgb_t RED    = 6'b11_00_00;
  localparam rgb_t YELLOW = 6'b11_11_00;
  localparam rgb_t BLUE   = 6'b00_00_11;
  localparam rgb_t WHITE  = 6'b11_11_11;

  typedef enum logic [1:0] {
    EMPTY   = 2'b00,
    PLAYER1 = 2'b01,
    PLAYER2 = 2'b10
  } player_t;

endpackage

// File: rtl/vga_timing.sv
// Free-running VGA h/v counters with raw (unregistered) syncs, active flag
// and the frame-counter bit that drives the game-over blink.
module vga_timing #(
  parameter int H_ACTIVE  = vga_pkg::H_ACTIVE,
  parameter int H_FP      = vga_pkg::H_FP,
  parameter int H_SYNC    = vga_pkg::H_SYNC,
  parameter int H_BP      = vga_pkg::H_BP,
  parameter int V_ACTIVE  = vga_pkg::V_ACTIVE,
  parameter int V_FP      = vga_pkg::V_FP,
  parameter int V_SYNC    = vga_pkg::V_SYNC,
  parameter int V_BP      = vga_pkg::V_BP,
  parameter int BLINK_BIT = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [9:0] h_cnt,
  output logic [9:0] v_cnt,
  output logic       hsync_raw,
  output logic       vsync_raw,
  output logic       active,
  output logic       blink_phase
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  logic [5:0] frame_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt     <= '0;
      v_cnt     <= '0;
      frame_cnt <= '0;
    end else if (h_cnt == 10'(H_TOTAL - 1)) begin
      h_cnt <= '0;
      if (v_cnt == 10'(V_TOTAL - 1)) begin
        v_cnt     <= '0;
        frame_cnt <= frame_cnt + 6'd1;
      end else begin
        v_cnt <= v_cnt + 10'd1;
      end
    end else begin
      h_cnt <= h_cnt + 10'd1;
    end
  end

  assign hsync_raw   = !((h_cnt >= 10'(H_ACTIVE + H_FP)) &&
                         (h_cnt <  10'(H_ACTIVE + H_FP + H_SYNC)));
  assign vsync_raw   = !((v_cnt >= 10'(V_ACTIVE + V_FP)) &&
                         (v_cnt <  10'(V_ACTIVE + V_FP + V_SYNC)));
  assign active      = (h_cnt < 10'(H_ACTIVE)) && (v_cnt < 10'(V_ACTIVE));
  assign blink_phase = frame_cnt[BLINK_BIT];

endmodule

// File: rtl/vga_board_renderer.sv
// Renders the connect-four board, drop cursor and game-over blink as VGA,
// reading cells through a two-cycle lookahead on the core's read port.
module vga_board_renderer #(
  parameter int H_ACTIVE   = vga_pkg::H_ACTIVE,
  parameter int H_FP       = vga_pkg::H_FP,
  parameter int H_SYNC     = vga_pkg::H_SYNC,
  parameter int H_BP       = vga_pkg::H_BP,
  parameter int V_ACTIVE   = vga_pkg::V_ACTIVE,
  parameter int V_FP       = vga_pkg::V_FP,
  parameter int V_SYNC     = vga_pkg::V_SYNC,
  parameter int V_BP       = vga_pkg::V_BP,
  parameter int BOARD_X0   = vga_pkg::BOARD_X0,
  parameter int BOARD_Y0   = vga_pkg::BOARD_Y0,
  parameter int CELL_SHIFT = vga_pkg::CELL_SHIFT,
  parameter int FLIP_ROWS  = vga_pkg::FLIP_ROWS,
  parameter int BLINK_BIT  = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] cell_data,
  input  logic [2:0] current_col,
  input  logic [1:0] current_player,
  input  logic       game_over,
  output logic [2:0] row_read,
  output logic [2:0] col_read,
  output logic       hsync,
  output logic       vsync,
  output logic [1:0] red,
  output logic [1:0] green,
  output logic [1:0] blue,
  output logic       display_on
);
  import vga_pkg::*;

  localparam int CELL    = 1 << CELL_SHIFT;
  localparam int HALF    = CELL / 2;
  localparam int R2      = (HALF - 2) * (HALF - 2);
  localparam int BOARD_W = 8 * CELL;

  logic [9:0]  h_cnt, v_cnt;
  logic        hsync_raw, vsync_raw, active, blink_phase;
  logic [11:0] x, y, x_ahead, rel_x, rel_y, rel_xa, rel_cy;
  logic        in_bx, in_by, in_bxa, in_cy, in_disc, blink;
  logic [2:0]  pix_col, scan_row;
  logic signed [15:0] dx, dy, dist2;
  rgb_t        pix;

  vga_timing #(
    .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
    .BLINK_BIT(BLINK_BIT)
  ) u_timing (
    .clk        (clk),
    .rst_n      (rst_n),
    .h_cnt      (h_cnt),
    .v_cnt      (v_cnt),
    .hsync_raw  (hsync_raw),
    .vsync_raw  (vsync_raw),
    .active     (active),
    .blink_phase(blink_phase)
  );

  // Offsets wrap for coordinates left of / above the board, so a single
  // unsigned compare against the board width is the range test.
  assign x       = {2'b00, h_cnt};
  assign y       = {2'b00, v_cnt};
  assign x_ahead = x + 12'd2;
  assign rel_x   = x - 12'(BOARD_X0);
  assign rel_xa  = x_ahead - 12'(BOARD_X0);
  assign rel_y   = y - 12'(BOARD_Y0);
  assign rel_cy  = y - 12'(BOARD_Y0 - CELL);

  assign in_bx   = rel_x  < 12'(BOARD_W);
  assign in_bxa  = rel_xa < 12'(BOARD_W);
  assign in_by   = rel_y  < 12'(BOARD_W);
  assign in_cy   = rel_cy < 12'(CELL);

  assign pix_col  = rel_x[CELL_SHIFT+2:CELL_SHIFT];
  assign scan_row = (FLIP_ROWS != 0) ? 3'd7 - rel_y[CELL_SHIFT+2:CELL_SHIFT]
                                     : rel_y[CELL_SHIFT+2:CELL_SHIFT];

  // Disc is centred on each cell measured from the board origin; the cursor
  // strip sits exactly one cell above, so rel_y gives its offset too.
  assign dx      = signed'(16'(rel_x[CELL_SHIFT-1:0])) - signed'(16'(HALF));
  assign dy      = signed'(16'(rel_y[CELL_SHIFT-1:0])) - signed'(16'(HALF));
  assign dist2   = dx * dx + dy * dy;
  assign in_disc = dist2 < signed'(16'(R2));
  assign blink   = game_over && blink_phase;

  always_comb begin
    pix = BLACK;
    if (!active) begin
      pix = BLACK;
    end else if (in_bx && in_cy && pix_col == current_col && in_disc) begin
      if (blink)                          pix = BLACK;
      else if (current_player == PLAYER2) pix = YELLOW;
      else                                pix = RED;
    end else if (in_bx && in_by) begin
      if (in_disc) begin
        case (cell_data)
          EMPTY:   pix = BLACK;
          PLAYER1: pix = RED;
          PLAYER2: pix = YELLOW;
          default: pix = WHITE;
        endcase
      end else begin
        pix = blink ? WHITE : BLUE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync      <= 1'b1;
      vsync      <= 1'b1;
      red        <= '0;
      green      <= '0;
      blue       <= '0;
      display_on <= 1'b0;
      row_read   <= '0;
      col_read   <= '0;
    end else begin
      hsync      <= hsync_raw;
      vsync      <= vsync_raw;
      red        <= pix[5:4];
      green      <= pix[3:2];
      blue       <= pix[1:0];
      display_on <= active;
      if (in_bxa && in_by) begin
        col_read <= rel_xa[CELL_SHIFT+2:CELL_SHIFT];
        row_read <= scan_row;
      end
    end
  end

endmodule

// File: tb/tb_vga_board_renderer.sv
// Self-checking bench for vga_board_renderer on a scaled-down raster
// (100x90 total, 8-pixel cells) so several frames fit in a short run.
module tb_vga_board_renderer;

  localparam int HA = 88, HFP = 2, HS = 6, HB = 4;
  localparam int VA = 84, VFP = 2, VS = 2, VB = 2;
  localparam int HT = HA + HFP + HS + HB;
  localparam int VT = VA + VFP + VS + VB;
  localparam int FRAME = HT * VT;
  localparam int X0 = 16, Y0 = 16, CS = 3;
  localparam int CELL = 8, HALF = 4, R2 = 4;
  localparam int BB = 1;

  localparam int C_BLACK = 'h00, C_RED = 'h30, C_YELLOW = 'h3C;
  localparam int C_BLUE = 'h03, C_WHITE = 'h3F;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] cell_data = '0;
  logic [2:0] current_col = '0;
  logic [1:0] current_player = 2'b01;
  logic       game_over = 1'b0;
  logic [2:0] row_read, col_read;
  logic       hsync, vsync, display_on;
  logic [1:0] red, green, blue;

  logic [1:0] bd [8][8];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int exp_row = 0, exp_col = 0;
  int hlow = 0, vlow = 0, vfall_last = -1;
  bit hprev = 1'b1, vprev = 1'b1;
  bit directed_on = 1'b0;
  bit randomize_inputs = 1'b0;

  always #5 clk = ~clk;

  // Board memory of the game core: one-cycle registered read.
  always @(posedge clk) cell_data <= bd[row_read][col_read];

  vga_board_renderer #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VB),
    .BOARD_X0(X0), .BOARD_Y0(Y0), .CELL_SHIFT(CS), .FLIP_ROWS(1),
    .BLINK_BIT(BB)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cell_data     (cell_data),
    .current_col   (current_col),
    .current_player(current_player),
    .game_over     (game_over),
    .row_read      (row_read),
    .col_read      (col_read),
    .hsync         (hsync),
    .vsync         (vsync),
    .red           (red),
    .green         (green),
    .blue          (blue),
    .display_on    (display_on)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Colour of pixel index p of the run (counted from reset release).
  function automatic int model_rgb(input int p, input int col, input int pl, input bit go);
    int h, v, fr, bx, by, ox, oy;
    bit blink, disc;
    h  = p % HT;
    v  = (p / HT) % VT;
    fr = p / FRAME;
    if (h >= HA || v >= VA) return C_BLACK;
    if (h < X0 || h >= X0 + 8 * CELL) return C_BLACK;
    blink = go && (((fr >> BB) & 1) == 1);
    bx = (h - X0) / CELL;
    ox = (h - X0) % CELL - HALF;
    if (v >= Y0 - CELL && v < Y0) begin
      oy = (v - (Y0 - CELL)) % CELL - HALF;
      disc = (ox * ox + oy * oy) < R2;
      if (disc && bx == col) return blink ? C_BLACK : (pl == 2 ? C_YELLOW : C_RED);
      return C_BLACK;
    end
    if (v >= Y0 && v < Y0 + 8 * CELL) begin
      by = (v - Y0) / CELL;
      oy = (v - Y0) % CELL - HALF;
      disc = (ox * ox + oy * oy) < R2;
      if (!disc) return blink ? C_WHITE : C_BLUE;
      case (bd[7 - by][bx])
        2'b01:   return C_RED;
        2'b10:   return C_YELLOW;
        2'b11:   return C_WHITE;
        default: return C_BLACK;
      endcase
    end
    return C_BLACK;
  endfunction

  task automatic check_reset_state(input string tag);
    check({tag, "_hsync"}, hsync, 1);
    check({tag, "_vsync"}, vsync, 1);
    check({tag, "_rgb"}, {red, green, blue}, 0);
    check({tag, "_display_on"}, display_on, 0);
    check({tag, "_row_read"}, row_read, 0);
    check({tag, "_col_read"}, col_read, 0);
  endtask

  task automatic restart_model();
    cyc = 0; exp_row = 0; exp_col = 0;
    hlow = 0; vlow = 0; vfall_last = -1;
    hprev = 1'b1; vprev = 1'b1;
  endtask

  // One clock: outputs after this edge reflect counter state p = cyc-1,
  // computed with the inputs that were held during that cycle.
  task automatic step();
    int q_col, q_pl, p, h, v, fr, xa, rgb;
    bit q_go;
    q_col = current_col; q_pl = current_player; q_go = game_over;
    @(posedge clk);
    #1;
    cyc++;
    p = cyc - 1; h = p % HT; v = (p / HT) % VT; fr = p / FRAME;
    rgb = {26'd0, red, green, blue};

    check("rgb", rgb, model_rgb(p, q_col, q_pl, q_go));
    check("hsync", hsync, (h >= HA + HFP && h < HA + HFP + HS) ? 0 : 1);
    check("vsync", vsync, (v >= VA + VFP && v < VA + VFP + VS) ? 0 : 1);
    check("display_on", display_on, (h < HA && v < VA) ? 1 : 0);

    xa = h + 2;
    if (xa >= X0 && xa < X0 + 8 * CELL && v >= Y0 && v < Y0 + 8 * CELL) begin
      exp_col = (xa - X0) / CELL;
      exp_row = 7 - (v - Y0) / CELL;
    end
    check("col_read", col_read, exp_col);
    check("row_read", row_read, exp_row);

    if (hsync === 1'b0) begin
      if (hprev) check("hsync_start_h", h, HA + HFP);
      hlow++;
    end else begin
      if (!hprev) check("hsync_width", hlow, HS);
      hlow = 0;
    end
    hprev = hsync;
    if (vsync === 1'b0) begin
      if (vprev) begin
        check("vsync_start_v", v, VA + VFP);
        if (vfall_last >= 0) check("frame_period", cyc - vfall_last, FRAME);
        vfall_last = cyc;
      end
      vlow++;
    end else begin
      if (!vprev) check("vsync_width", vlow, VS * HT);
      vlow = 0;
    end
    vprev = vsync;

    if (directed_on) begin
      if (v == Y0 + 2 && h == X0 - 2) begin
        check("addr_first_col", col_read, 0);
        check("addr_first_row", row_read, 7);
      end
      if (v == Y0 + 2 && h == X0 - 2 + CELL) check("addr_second_col", col_read, 1);
      if (v == Y0 + 7 * CELL + 4 && h == X0 + 3 * CELL + 4) check("cell_r0c3_red", rgb, C_RED);
      if (v == Y0 + 4 && h == X0 + 3 * CELL + 4) check("cell_r7c3_black", rgb, C_BLACK);
      if (fr == 0 && v == Y0 - CELL + 4 && h == X0 + 5 * CELL + 4) check("cursor_yellow", rgb, C_YELLOW);
      if (fr == 0 && v == Y0 - CELL + 4 && h == X0 + 4 * CELL + 4) check("cursor_other_col", rgb, C_BLACK);
      if (fr == 0 && v == Y0 + 1 && h == X0 + 1) check("frame_blue", rgb, C_BLUE);
      if (fr == 2 && v == Y0 + 1 && h == X0 + 1) check("frame_blink_white", rgb, C_WHITE);
      if (fr == 2 && v == Y0 - CELL + 4 && h == X0 + 5 * CELL + 4) check("cursor_blink_black", rgb, C_BLACK);
    end

    if (randomize_inputs && $urandom_range(0, 199) == 0) begin
      current_col    = 3'($urandom_range(0, 7));
      current_player = 2'($urandom_range(1, 2));
      game_over      = 1'($urandom_range(0, 1));
    end
  endtask

  initial begin
    int budget;

    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset");

    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        bd[r][c] = 2'($urandom_range(0, 3));
    bd[0][3] = 2'b01;
    bd[7][3] = 2'b00;
    current_col = 3'd5; current_player = 2'b10; game_over = 1'b1;

    @(negedge clk);
    rst_n = 1'b1;
    restart_model();
    directed_on = 1'b1;
    for (int i = 0; i < 4 * FRAME; i++) begin
      if (i == 3 * FRAME) randomize_inputs = 1'b1;
      step();
    end
    directed_on = 1'b0;

    budget = 0;
    while (!(((cyc - 1) / HT) % VT == 60 && (cyc - 1) % HT == 30) && budget < 2 * FRAME) begin
      step();
      budget++;
    end
    check("reach_mid_frame", budget < 2 * FRAME, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_state("async_reset");
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("held_reset");

    @(negedge clk);
    rst_n = 1'b1;
    restart_model();
    budget = 0;
    while (vfall_last < 0 && budget < 2 * FRAME) begin
      step();
      budget++;
    end
    check("first_vsync_after_reset", vfall_last, (VA + VFP) * HT + 1);
    repeat (200) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
